// File: rtl/fp_divider_seq.sv
// rtl/fp_divider_seq.sv - sequential IEEE-754 single-precision divider (restoring radix-2, RNE, flush-to-zero)
module fp_divider_seq (
    input  logic        CLK,
    input  logic        nRST,
    input  logic        start,
    input  logic [31:0] data1,
    input  logic [31:0] data2,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic        overflow,
    output logic        underflow,
    output logic        div_by_zero,
    output logic        invalid
);

    typedef enum logic [1:0] {IDLE, DIVIDE, ROUND, DONE} state_t;

    state_t      state, state_next;
    logic [24:0] rem;
    logic [23:0] divisor;
    logic [24:0] quo;
    logic [9:0]  exp_q;
    logic        sign_q;
    logic [4:0]  cnt;

    logic        sign_r;
    logic [7:0]  exp1, exp2;
    logic [22:0] man1, man2;
    logic        zero1, zero2, inf1, inf2, nan1, nan2;
    logic        special, spec_invalid, spec_dbz;
    logic [31:0] spec_result;
    logic        accept;

    assign exp1   = data1[30:23];
    assign exp2   = data2[30:23];
    assign man1   = data1[22:0];
    assign man2   = data2[22:0];
    assign sign_r = data1[31] ^ data2[31];
    // Subnormals count as zero; only exponent 255 distinguishes inf from NaN.
    assign zero1  = (exp1 == 8'd0);
    assign zero2  = (exp2 == 8'd0);
    assign inf1   = (exp1 == 8'hFF) && (man1 == 23'd0);
    assign inf2   = (exp2 == 8'hFF) && (man2 == 23'd0);
    assign nan1   = (exp1 == 8'hFF) && (man1 != 23'd0);
    assign nan2   = (exp2 == 8'hFF) && (man2 != 23'd0);
    assign accept = (state == IDLE) && start && !done;
    assign busy   = (state != IDLE);

    always_comb begin
        special      = 1'b1;
        spec_invalid = 1'b0;
        spec_dbz     = 1'b0;
        spec_result  = 32'h7FC0_0000;
        if (nan1 || nan2) begin
            spec_result = 32'h7FC0_0000;
        end else if ((zero1 && zero2) || (inf1 && inf2)) begin
            spec_invalid = 1'b1;
        end else if (inf1) begin
            spec_result = {sign_r, 8'hFF, 23'd0};
        end else if (zero2) begin
            spec_dbz    = 1'b1;
            spec_result = {sign_r, 8'hFF, 23'd0};
        end else if (zero1 || inf2) begin
            spec_result = {sign_r, 31'd0};
        end else begin
            special = 1'b0;
        end
    end

    // Normalised dividend lies in [mb, 2*mb), so the first quotient bit is always 1
    // and is resolved on the accepting edge; only the remaining 25 bits are stored.
    logic [23:0] ma, mb;
    logic        a_lt_b;
    logic [24:0] dividend;
    logic [9:0]  exp_init;
    logic [24:0] first_rem;

    assign ma        = {1'b1, man1};
    assign mb        = {1'b1, man2};
    assign a_lt_b    = (ma < mb);
    assign dividend  = a_lt_b ? {ma, 1'b0} : {1'b0, ma};
    assign exp_init  = 10'(exp1) - 10'(exp2) + 10'd127 - {9'd0, a_lt_b};
    assign first_rem = {24'(dividend - {1'b0, mb}), 1'b0};

    logic        step_ge;
    logic [23:0] step_sub;
    assign step_ge  = (rem >= {1'b0, divisor});
    assign step_sub = step_ge ? 24'(rem - {1'b0, divisor}) : rem[23:0];

    logic        rnd_inc;
    logic [23:0] frac_sum;
    logic [9:0]  exp_rnd;
    logic        rnd_ovf, rnd_unf;

    assign rnd_inc  = quo[1] & (quo[0] | (rem != 25'd0) | quo[2]);
    assign frac_sum = {1'b0, quo[24:2]} + {23'd0, rnd_inc};
    // A carry out of the fraction leaves frac_sum[22:0] at zero, so only the exponent moves.
    assign exp_rnd  = exp_q + {9'd0, frac_sum[23]};
    assign rnd_ovf  = $signed(exp_rnd) >= $signed(10'sd255);
    assign rnd_unf  = $signed(exp_rnd) <= $signed(10'sd0);

    always_comb begin
        state_next = state;
        case (state)
            IDLE:   if (accept) state_next = special ? DONE : DIVIDE;
            DIVIDE: if (cnt == 5'd24) state_next = ROUND;
            ROUND:  state_next = DONE;
            DONE:   state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state       <= IDLE;
            rem         <= '0;
            divisor     <= '0;
            quo         <= '0;
            exp_q       <= '0;
            sign_q      <= 1'b0;
            cnt         <= '0;
            result      <= '0;
            overflow    <= 1'b0;
            underflow   <= 1'b0;
            div_by_zero <= 1'b0;
            invalid     <= 1'b0;
            done        <= 1'b0;
        end else begin
            state <= state_next;
            done  <= (state == DONE);
            case (state)
                IDLE: begin
                    if (accept) begin
                        overflow    <= 1'b0;
                        underflow   <= 1'b0;
                        div_by_zero <= spec_dbz & special;
                        invalid     <= spec_invalid & special;
                        sign_q      <= sign_r;
                        if (special) begin
                            result <= spec_result;
                        end else begin
                            rem     <= first_rem;
                            divisor <= mb;
                            quo     <= '0;
                            exp_q   <= exp_init;
                            cnt     <= '0;
                        end
                    end
                end
                DIVIDE: begin
                    rem <= {step_sub, 1'b0};
                    quo <= {quo[23:0], step_ge};
                    cnt <= cnt + 5'd1;
                end
                ROUND: begin
                    if (rnd_ovf) begin
                        result   <= {sign_q, 8'hFF, 23'd0};
                        overflow <= 1'b1;
                    end else if (rnd_unf) begin
                        result    <= {sign_q, 31'd0};
                        underflow <= 1'b1;
                    end else begin
                        result <= {sign_q, exp_rnd[7:0], frac_sum[22:0]};
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_divider_seq.sv
// tb/tb_fp_divider_seq.sv - scoreboard bench for fp_divider_seq against an integer-division reference model
module tb_fp_divider_seq;

    logic        CLK = 1'b0;
    logic        nRST = 1'b0;
    logic        start = 1'b0;
    logic [31:0] data1 = '0;
    logic [31:0] data2 = '0;
    logic        busy, done, overflow, underflow, div_by_zero, invalid;
    logic [31:0] result;

    fp_divider_seq dut (
        .CLK(CLK), .nRST(nRST), .start(start), .data1(data1), .data2(data2),
        .busy(busy), .done(done), .result(result), .overflow(overflow),
        .underflow(underflow), .div_by_zero(div_by_zero), .invalid(invalid)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] res;
        logic [3:0]  fl;
        int          issue;
        int          lat;
        int          blen;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_err = 0;
    int   busy_cnt = 0;
    int   n_done = 0;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
        n_vec++;
        if (got !== want) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, got, want, $time);
        end
    endtask

    // Reference: quotient as a wide integer division, then generic round-to-nearest-even to 24 bits.
    function automatic void ref_div(input logic [31:0] a, input logic [31:0] b,
                                    output logic [31:0] r, output logic [3:0] fl, output bit sp);
        logic            s;
        logic [7:0]      ea, eb;
        logic [22:0]     fa, fb;
        bit              za, zb, ia, ib, na, nb;
        longint unsigned num, den, q, rm, keep, dropped, half;
        int              msb, sh, e;
        bit              up;
        s  = a[31] ^ b[31];
        ea = a[30:23]; eb = b[30:23];
        fa = a[22:0];  fb = b[22:0];
        za = (ea == 0); zb = (eb == 0);
        ia = (ea == 8'hFF) && (fa == 0); ib = (eb == 8'hFF) && (fb == 0);
        na = (ea == 8'hFF) && (fa != 0); nb = (eb == 8'hFF) && (fb != 0);
        fl = 4'b0000;
        sp = 1;
        if (na || nb)                      r = 32'h7FC0_0000;
        else if ((za && zb) || (ia && ib)) begin r = 32'h7FC0_0000; fl = 4'b0001; end
        else if (ia)                       r = {s, 31'h7F80_0000};
        else if (zb)                       begin r = {s, 31'h7F80_0000}; fl = 4'b0010; end
        else if (za || ib)                 r = {s, 31'd0};
        else begin
            sp  = 0;
            num = longint'({1'b1, fa}) << 38;
            den = longint'({1'b1, fb});
            q   = num / den;
            rm  = num % den;
            msb = (q >= (64'd1 << 38)) ? 38 : 37;
            e   = int'(ea) - int'(eb) + 127 + msb - 38;
            sh  = msb - 23;
            keep    = q >> sh;
            dropped = q & ((64'd1 << sh) - 1);
            half    = 64'd1 << (sh - 1);
            up = (dropped > half) || (dropped == half && (rm != 0 || keep[0]));
            keep = keep + (up ? 1 : 0);
            if (keep == (64'd1 << 24)) begin
                keep = keep >> 1;
                e    = e + 1;
            end
            if (e >= 255)     begin r = {s, 31'h7F80_0000}; fl = 4'b1000; end
            else if (e <= 0)  begin r = {s, 31'd0};         fl = 4'b0100; end
            else               r = {s, 8'(e), keep[22:0]};
        end
    endfunction

    always @(negedge CLK) begin
        if (!nRST) begin
            busy_cnt = 0;
        end else if (done) begin
            n_done++;
            if (sb.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_done: got done=1 result %h expected no pending operation", result);
            end else begin
                mon_e = sb.pop_front();
                check("result", result, mon_e.res);
                check("flags", {28'd0, overflow, underflow, div_by_zero, invalid}, {28'd0, mon_e.fl});
                check("latency", 32'(cyc - mon_e.issue), 32'(mon_e.lat));
                check("busy_len", 32'(busy_cnt), 32'(mon_e.blen));
            end
            busy_cnt = 0;
        end else if (busy) begin
            busy_cnt++;
        end
    end

    // With overlap set, the first cycle coincides with done and must be ignored by the DUT.
    task automatic send(input logic [31:0] a, input logic [31:0] b, input bit overlap);
        exp_t e;
        bit   sp;
        data1 = a;
        data2 = b;
        start = 1'b1;
        if (overlap) @(negedge CLK);
        ref_div(a, b, e.res, e.fl, sp);
        e.issue = cyc;
        e.lat   = sp ? 2 : 28;
        e.blen  = sp ? 1 : 27;
        sb.push_back(e);
        @(negedge CLK);
        start = 1'b0;
    endtask

    task automatic wait_done(output bit ok);
        ok = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (done) begin
                ok = 1;
                return;
            end
        end
        n_vec++;
        n_err++;
        $display("FAIL done_timeout: got no done within 60 cycles expected done");
    endtask

    function automatic logic [31:0] rand_op();
        logic        s;
        logic [22:0] m;
        int          k;
        s = 1'($urandom_range(0, 1));
        m = 23'($urandom);
        k = $urandom_range(0, 11);
        case (k)
            0:       return {s, 8'd0, 23'd0};
            1:       return {s, 8'd0, m | 23'd1};
            2:       return {s, 8'hFF, 23'd0};
            3:       return {s, 8'hFF, m | 23'd1};
            4:       return {s, 8'($urandom_range(240, 254)), m};
            5:       return {s, 8'($urandom_range(1, 15)), m};
            default: return {s, 8'($urandom_range(110, 144)), m};
        endcase
    endfunction

    logic [31:0] dir_a [12] = '{32'h40C00000, 32'h3F800000, 32'h3F800000, 32'h00000000,
                                32'h7F000000, 32'h00800000, 32'hC0C00000, 32'h7FC00001,
                                32'h7F800000, 32'h7F800000, 32'h40000000, 32'h00000000};
    logic [31:0] dir_b [12] = '{32'h40000000, 32'h40400000, 32'h00000000, 32'h00000000,
                                32'h3E800000, 32'h40000000, 32'h40000000, 32'h3F800000,
                                32'h7F800000, 32'hC0000000, 32'h7F800000, 32'h40000000};

    initial begin
        bit ok;
        int saved_done;
        nRST = 1'b0;
        repeat (2) @(negedge CLK);
        check("reset_result", result, 32'd0);
        check("reset_ctrl", {26'd0, busy, done, overflow, underflow, div_by_zero, invalid}, 32'd0);
        nRST = 1'b1;
        @(negedge CLK);

        send(dir_a[0], dir_b[0], 0);
        wait_done(ok);
        for (int i = 1; i < 12; i++) begin
            send(dir_a[i], dir_b[i], ok);
            wait_done(ok);
        end
        for (int i = 0; i < 40; i++) begin
            send(rand_op(), rand_op(), ok);
            wait_done(ok);
        end

        @(negedge CLK);
        send(32'h40C00000, 32'h40000000, 0);
        repeat (3) @(negedge CLK);
        data1 = 32'h3F800000;
        data2 = 32'h00000000;
        start = 1'b1;
        @(negedge CLK);
        start = 1'b0;
        repeat (4) @(negedge CLK);
        nRST = 1'b0;
        #1;
        check("midreset_result", result, 32'd0);
        check("midreset_ctrl", {26'd0, busy, done, overflow, underflow, div_by_zero, invalid}, 32'd0);
        sb.delete();
        saved_done = n_done;
        repeat (2) @(negedge CLK);
        nRST = 1'b1;
        repeat (35) @(negedge CLK);
        check("no_done_after_reset", 32'(n_done), 32'(saved_done));
        check("result_after_reset", result, 32'd0);

        send(32'h3F800000, 32'h40400000, 0);
        wait_done(ok);
        @(negedge CLK);
        check("scoreboard_empty", 32'(sb.size()), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
